// File: rtl/lcd_pkg.sv
// lcd_pkg: opcodes shared with the LCD image controller plus the command sequencer state encoding.
package lcd_pkg;

    localparam logic [3:0] CMD_WRITE       = 4'd0;
    localparam logic [3:0] CMD_SHIFT_UP    = 4'd1;
    localparam logic [3:0] CMD_SHIFT_DOWN  = 4'd2;
    localparam logic [3:0] CMD_SHIFT_LEFT  = 4'd3;
    localparam logic [3:0] CMD_SHIFT_RIGHT = 4'd4;
    localparam logic [3:0] CMD_MAX         = 4'd5;
    localparam logic [3:0] CMD_MIN         = 4'd6;
    localparam logic [3:0] CMD_AVERAGE     = 4'd7;
    localparam logic [3:0] CMD_ROT_CCW     = 4'd8;
    localparam logic [3:0] CMD_ROT_CW      = 4'd9;
    localparam logic [3:0] CMD_MIRROR_X    = 4'd10;
    localparam logic [3:0] CMD_MIRROR_Y    = 4'd11;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_READY,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_FREE,
        ST_WAIT_DONE,
        ST_FINISH
    } seq_state_t;

    function automatic logic is_legal(input logic [3:0] c);
        return c <= CMD_MIRROR_Y;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: synchronous FIFO of DEPTH entries of W bits.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_push, i_data : write strobe and data (ignored when full)
//   i_pop          : read strobe (ignored when empty)
//   o_data         : head entry, valid while !o_empty
//   o_full/o_empty : occupancy flags
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_wr_en;

    assign w_wr_en = i_push && !o_full;
    // Extra pointer MSB tells a wrapped (full) writer apart from an equal (empty) one.
    assign o_empty = r_wr == r_rd;
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_data  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_wr_en)
            r_mem[r_wr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en)
                r_wr <= r_wr + PTR_ONE;
            if (i_pop && !o_empty)
                r_rd <= r_rd + PTR_ONE;
        end
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: queues host opcodes and issues them one at a time to the LCD controller.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_host_cmd/i_host_valid : host opcode offer; o_host_ready accepts it
//   o_cmd/o_cmd_valid       : opcode to controller, one-cycle issue strobe
//   i_busy, i_done          : controller busy and frame-written indications
//   o_seq_idle              : nothing queued and nothing outstanding
//   o_illegal               : pulse on an accepted opcode 12-15 (dropped)
//   o_ack_to                : sticky, busy never rose after an issue
//   o_issued_cnt            : saturating count of issued commands
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_host_cmd,
    input  logic       i_host_valid,
    output logic       o_host_ready,
    output logic [3:0] o_cmd,
    output logic       o_cmd_valid,
    input  logic       i_busy,
    input  logic       i_done,
    output logic       o_seq_idle,
    output logic       o_illegal,
    output logic       o_ack_to,
    output logic [7:0] o_issued_cnt
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    seq_state_t      r_state;
    seq_state_t      w_next;
    logic [3:0]      r_cmd;
    logic [3:0]      w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_to_hit;
    logic            r_ack_to;
    logic [7:0]      r_issued;
    logic [TW-1:0]   r_to_cnt;

    assign o_host_ready = !w_full && r_state != ST_FINISH && r_state != ST_WAIT_DONE;
    assign w_accept     = i_host_valid && o_host_ready;
    assign w_push       = w_accept && is_legal(i_host_cmd);
    assign o_illegal    = w_accept && !is_legal(i_host_cmd);
    assign o_cmd        = r_cmd;
    assign o_cmd_valid  = r_state == ST_ISSUE;
    assign o_seq_idle   = w_empty && r_state == ST_READY;
    assign o_ack_to     = r_ack_to;
    assign o_issued_cnt = r_issued;
    assign w_to_hit     = r_state == ST_WAIT_ACK && !i_busy && r_to_cnt == TW'(ACK_TIMEOUT - 1);

    lcd_cmd_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  (i_host_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            ST_INIT:      w_next = i_busy ? ST_INIT : ST_READY;
            ST_READY: begin
                w_pop  = !w_empty && !i_busy;
                w_next = w_pop ? ST_ISSUE : ST_READY;
            end
            ST_ISSUE:     w_next = ST_WAIT_ACK;
            ST_WAIT_ACK:  w_next = (i_busy || w_to_hit) ? ST_WAIT_FREE : ST_WAIT_ACK;
            // A write ends the frame: nothing queued behind it is ever issued.
            ST_WAIT_FREE: w_next = i_busy ? ST_WAIT_FREE : (r_cmd == CMD_WRITE ? ST_WAIT_DONE : ST_READY);
            ST_WAIT_DONE: w_next = i_done ? ST_FINISH : ST_WAIT_DONE;
            ST_FINISH:    w_next = ST_FINISH;
            default:      w_next = ST_INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_INIT;
            r_cmd    <= CMD_WRITE;
            r_ack_to <= 1'b0;
            r_issued <= '0;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_to_cnt <= (r_state == ST_WAIT_ACK) ? r_to_cnt + TW'(1) : '0;
            if (w_pop)
                r_cmd <= w_head;
            if (r_state == ST_ISSUE && r_issued != 8'hFF)
                r_issued <= r_issued + 8'd1;
            if (w_to_hit)
                r_ack_to <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: scoreboard bench with a behavioural controller model and randomized host traffic.
module tb_lcd_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] host_cmd = 4'd0;
    logic       host_valid = 1'b0;
    logic       done = 1'b0;
    logic       hold_busy = 1'b0;
    logic       ctrl_busy = 1'b0;
    logic       no_ack = 1'b0;
    logic       busy;
    logic       o_host_ready, o_cmd_valid, o_seq_idle, o_illegal, o_ack_to;
    logic [3:0] o_cmd;
    logic [7:0] o_issued_cnt;

    int         busy_dur = 3;
    int         cyc = 0;
    int         total = 0;
    int         passed = 0;
    int         n_issued = 0;
    int         last_cv = -100;
    int         push_cyc = 0;
    int         cv_cyc = 0;
    bit         wrote = 1'b0;
    bit         acc;
    logic [3:0] exp_q[$];
    logic [3:0] burst[6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};

    assign busy = hold_busy | ctrl_busy;

    lcd_cmd_sequencer #(.DEPTH(4), .ACK_TIMEOUT(4)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_host_cmd   (host_cmd),
        .i_host_valid (host_valid),
        .o_host_ready (o_host_ready),
        .o_cmd        (o_cmd),
        .o_cmd_valid  (o_cmd_valid),
        .i_busy       (busy),
        .i_done       (done),
        .o_seq_idle   (o_seq_idle),
        .o_illegal    (o_illegal),
        .o_ack_to     (o_ack_to),
        .o_issued_cnt (o_issued_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer op until accepted or max_wait cycles; the model queues legal ops
    // unless a write has already been queued (those are never issued).
    task automatic push(input logic [3:0] op, input int max_wait, output bit ok);
        host_cmd = op;
        host_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            if (o_host_ready) begin
                ok = 1'b1;
                push_cyc = cyc;
                chk("illegal_flag", int'(o_illegal), int'(op >= 4'd12));
                if (op < 4'd12 && !wrote) exp_q.push_back(op);
                if (op == 4'd0) wrote = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        host_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_wait);
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (o_seq_idle && !busy && exp_q.size() == 0) break;
        end
        chk("reach_idle", int'(o_seq_idle), 1);
        chk("all_issued", exp_q.size(), 0);
        tick();
    endtask

    // Controller model: busy rises one cycle after the strobe and holds for
    // busy_dur cycles; a write is followed by done ten cycles later.
    initial begin
        logic [3:0] c;
        forever begin
            @(negedge clk);
            if (o_cmd_valid && !no_ack && !reset) begin
                c = o_cmd;
                @(posedge clk);
                #1 ctrl_busy = 1'b1;
                repeat (busy_dur) @(posedge clk);
                #1 ctrl_busy = 1'b0;
                if (c == 4'd0) begin
                    repeat (10) @(posedge clk);
                    #1 done = 1'b1;
                    @(posedge clk);
                    #1 done = 1'b0;
                end
            end
        end
    end

    // Monitor: every issue strobe pops the scoreboard.
    initial begin
        bit pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
                last_cv = -100;
            end else begin
                if (pend) begin
                    chk("issued_cnt", int'(o_issued_cnt), n_issued);
                    pend = 1'b0;
                end
                if (o_cmd_valid) begin
                    cv_cyc = cyc;
                    chk("issue_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) chk("cmd", int'(o_cmd), int'(exp_q.pop_front()));
                    chk("issue_spacing", int'(cyc - last_cv >= 4), 1);
                    last_cv = cyc;
                    n_issued = (n_issued < 255) ? n_issued + 1 : 255;
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int p;
        logic [3:0] op;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd", int'(o_cmd), 0);
        chk("rst_cmd_valid", int'(o_cmd_valid), 0);
        chk("rst_host_ready", int'(o_host_ready), 1);
        chk("rst_seq_idle", int'(o_seq_idle), 0);
        chk("rst_illegal", int'(o_illegal), 0);
        chk("rst_ack_to", int'(o_ack_to), 0);
        chk("rst_issued_cnt", int'(o_issued_cnt), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();

        busy_dur = 3;
        push(4'd5, 10, acc);
        chk("single_accept", int'(acc), 1);
        p = push_cyc;
        wait_idle(50);
        chk("push_to_issue_latency", cv_cyc - p, 2);
        chk("single_issued_cnt", int'(o_issued_cnt), 1);

        push(4'd13, 10, acc);
        @(negedge clk);
        chk("illegal_one_cycle", int'(o_illegal), 0);
        repeat (5) tick();
        chk("illegal_not_queued", int'(o_seq_idle), 1);
        chk("illegal_cnt_same", int'(o_issued_cnt), 1);

        for (int i = 0; i < 40; i++) begin
            busy_dur = $urandom_range(1, 4);
            op = 4'($urandom_range(1, 15));
            push(op, 60, acc);
            chk("rand_accept", int'(acc), 1);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle(400);

        hold_busy = 1'b1;
        busy_dur = 2;
        for (int i = 0; i < 4; i++) begin
            push(burst[i], 5, acc);
            chk("burst_accept", int'(acc), 1);
        end
        @(negedge clk);
        chk("burst_full_not_ready", int'(o_host_ready), 0);
        tick();
        hold_busy = 1'b0;
        for (int i = 4; i < 6; i++) begin
            push(burst[i], 60, acc);
            chk("burst_tail_accept", int'(acc), 1);
        end
        wait_idle(200);

        no_ack = 1'b1;
        push(4'd6, 10, acc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_cmd_valid) break;
        end
        chk("noack_issue_seen", int'(o_cmd_valid), 1);
        repeat (4) @(negedge clk);
        chk("ack_to_not_yet", int'(o_ack_to), 0);
        @(negedge clk);
        chk("ack_to_set", int'(o_ack_to), 1);
        tick();
        no_ack = 1'b0;
        busy_dur = 3;
        push(4'd10, 20, acc);
        wait_idle(100);
        chk("ack_to_sticky", int'(o_ack_to), 1);

        push(4'd7, 10, acc);
        push(4'd0, 10, acc);
        push(4'd3, 10, acc);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("write_waiting_ready_low", int'(o_host_ready), 0);
        repeat (20) @(negedge clk);
        chk("finish_ready_low", int'(o_host_ready), 0);
        chk("finish_not_idle", int'(o_seq_idle), 0);
        chk("finish_pending", exp_q.size(), 0);
        chk("finish_issued_cnt", int'(o_issued_cnt), n_issued);
        tick();
        push(4'd4, 5, acc);
        chk("finish_refuses_push", int'(acc), 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        wrote = 1'b0;
        n_issued = 0;
        tick();
        busy_dur = 8;
        push(4'd1, 10, acc);
        push(4'd2, 10, acc);
        push(4'd3, 10, acc);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        n_issued = 0;
        @(negedge clk);
        chk("mid_rst_cmd", int'(o_cmd), 0);
        chk("mid_rst_cmd_valid", int'(o_cmd_valid), 0);
        chk("mid_rst_host_ready", int'(o_host_ready), 1);
        chk("mid_rst_seq_idle", int'(o_seq_idle), 0);
        chk("mid_rst_ack_to", int'(o_ack_to), 0);
        chk("mid_rst_issued_cnt", int'(o_issued_cnt), 0);
        repeat (30) @(negedge clk);
        chk("post_rst_idle", int'(o_seq_idle), 1);
        chk("post_rst_issued_cnt", int'(o_issued_cnt), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Upstream command feeder for the 8x8 LCD image controller. Buffers image-operation opcodes from a host in a small FIFO and issues them to the controller one at a time over the controller's `cmd`/`cmd_valid`/`busy` handshake. Tracks the terminating write command (opcode 0) through to the controller's `done`, then locks until reset.

## Interface
- `DEPTH`, 4: command FIFO depth; must be a power of two, ≥2.
- `ACK_TIMEOUT`, 4: cycles allowed for `busy` to rise after an issue.

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `host_cmd`  in  4  opcode from host (0 write, 1–4 shift up/down/left/right, 5 max, 6 min, 7 average, 8 CCW, 9 CW, 10 mirror X, 11 mirror Y).
- `host_valid`  in  1  `host_cmd` is valid this cycle.
- `host_ready`  out  1  FIFO can accept; a transfer occurs when `host_valid & host_ready`.
- `cmd`  out  4  opcode to the controller.
- `cmd_valid`  out  1  one-cycle issue strobe.
- `busy`  in  1  controller busy; issue only while low.
- `done`  in  1  controller finished writing the frame.
- `seq_idle`  out  1  FIFO empty and no command outstanding.
- `illegal`  out  1  one-cycle pulse when a host transfer carries an opcode of 12–15; the opcode is dropped and not queued.
- `ack_to`  out  1  sticky; set when `busy` fails to rise within `ACK_TIMEOUT`.
- `issued_cnt`  out  8  number of commands issued, saturating at 255.

## Operation
- FIFO: `DEPTH` entries of 4 bits; pointers are log2(`DEPTH`)+1 bits wide, with the MSB used to distinguish full from empty.
  - `host_ready` = !full && state != FINISH && state != WAIT_DONE.
  - Illegal opcodes are still handshaken (ready honoured) but discarded.
- FSM states:
  - **INIT**: after reset. Go to READY when `busy`=0.
  - **READY**: when the FIFO is non-empty and `busy`=0, pop the head into `cmd_r` and go to ISSUE.
  - **ISSUE**: `cmd_valid`=1, `cmd`=`cmd_r`, `issued_cnt`++. Next state is WAIT_ACK.
  - **WAIT_ACK**: on `busy`=1 go to WAIT_FREE. If a timeout counter reaches `ACK_TIMEOUT` first, set `ack_to` and go to WAIT_FREE.
  - **WAIT_FREE**: on `busy`=0:
    - if `cmd_r`==0, go to WAIT_DONE;
    - else go to READY.
  - **WAIT_DONE**: on `done`=1 go to FINISH.
  - **FINISH**: terminal until `reset`.
    - FIFO contents are frozen; commands queued behind a write are never issued.
- `cmd` holds `cmd_r` in every state; `cmd_valid` is 1 only in ISSUE.
- `seq_idle` = empty && state==READY.
- Simultaneous push and pop in READY is permitted, including when the FIFO is full: the pop frees a slot next cycle, but `host_ready` is computed from the current full flag, so the push is refused that cycle.

## Timing
- Reset values:
  - state INIT, FIFO empty, `cmd_r`=0.
  - `cmd`=0, `cmd_valid`=0, `host_ready`=1, `seq_idle`=0 (INIT), `illegal`=0, `ack_to`=0, `issued_cnt`=0.
- Push-to-issue latency with the controller free and the FIFO empty:
  - push accepted at edge N;
  - READY pops at edge N+1;
  - `cmd_valid` is high during cycle N+1 → N+2.
  - This gives 2 cycles from the `host_valid` cycle to the `cmd_valid` cycle.
- Minimum spacing between issues is 4 cycles: ISSUE, WAIT_ACK (≥1), WAIT_FREE (≥1), READY.
- `done` sampled in states other than WAIT_DONE is ignored.
- Reset asserted mid-operation (any state) returns all of the above to reset values on the next edge; the outstanding command is abandoned.

## Structure
- Shared package `lcd_pkg` holds:
  - opcode constants (`CMD_WRITE`=0 … `CMD_MIRROR_Y`=11), reused by the controller;
  - the sequencer state encoding (3 bits).
- One sub-module: `lcd_cmd_fifo` (parameterised synchronous FIFO with push/pop/full/empty).
- FSM, timeout counter and statistics stay in the top.

## Test plan
- Reset, then push opcode 5 with `busy`=0; model raises `busy` 1 cycle after `cmd_valid` and holds it for 3 cycles → `cmd`=5, `cmd_valid` high exactly 1 cycle, 2 cycles after the push; `issued_cnt`=1; `seq_idle`=1 after `busy` falls.
- Burst-push 6 opcodes (1,2,3,4,8,9) with `DEPTH`=4 and the controller held busy → `host_ready` low after 4 accepted; all 6 eventually issued in order, with ≥4 cycles between `cmd_valid` pulses.
- Push opcode 13 → `illegal` pulses 1 cycle; nothing queued; `issued_cnt` unchanged.
- Push 7, then 0, then 3; model asserts `done` 10 cycles after the write completes → 7 and 0 issued, 3 never issued; `host_ready` stays 0 from the write's WAIT_FREE exit onward; FINISH persists.
- Model never raises `busy` → `ack_to` sets after 4 cycles in WAIT_ACK and stays set; the next command still issues.
- Assert `reset` for 1 cycle during WAIT_FREE with 2 entries queued → all outputs return to reset values; FIFO empty; no further `cmd_valid` occurs.
